// File: rtl/muldiv_sequencer_if.sv
// Handshake and operand/result bundle between the execute stage and the RV32M sequencer.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output flush, in_valid, funct3, op_a, op_b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  flush, in_valid, funct3, op_a, op_b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply (shift-add) / divide (restoring) sequencer beside the execute-stage ALU.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier is zero.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]        op;
    logic              sign_a, sign_b, spec;
    logic [XLEN-1:0]   opnd;      // multiplicand for MUL*, divisor for DIV*/REM*
    logic [2*XLEN-1:0] acc;       // {product hi, product lo/multiplier} or {rem, quot}
    logic [5:0]        cnt;
    logic [XLEN-1:0]   res_q;
`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0]   mplier;
`endif

    // Operand decode at acceptance
    logic            accept, in_div, in_sa, in_sb, in_spec;
    logic [XLEN-1:0] in_a_abs, in_b_abs, in_spec_res;

    assign accept = (state == IDLE) && bus.in_valid && !bus.flush;

    always_comb begin
        in_div      = bus.funct3[2];
        in_sa       = bus.op_a[XLEN-1] & (in_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11));
        in_sb       = bus.op_b[XLEN-1] & (in_div ? ~bus.funct3[0] : ~bus.funct3[1]);
        in_a_abs    = in_sa ? -bus.op_a : bus.op_a;
        in_b_abs    = in_sb ? -bus.op_b : bus.op_b;
        in_spec     = 1'b0;
        in_spec_res = '0;
        if (in_div && bus.op_b == '0) begin
            in_spec     = 1'b1;
            in_spec_res = bus.funct3[1] ? bus.op_a : '1;
        end else if (in_div && !bus.funct3[0] && bus.op_a == MIN_NEG && bus.op_b == '1) begin
            in_spec     = 1'b1;
            in_spec_res = bus.funct3[1] ? '0 : MIN_NEG;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!in_div && bus.op_b == '0) begin
            in_spec     = 1'b1;
            in_spec_res = '0;
        end
`endif
    end

    // One iteration step plus the sign fix / result select on exit
    logic [XLEN:0]     mul_sum, rem_sh;
    logic [XLEN-1:0]   rem_sub, quot_s, rem_s, fix_res;
    logic [2*XLEN-1:0] mul_nx, div_nx, prod, prod_s;
    logic              last;

    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nx  = {mul_sum, acc[XLEN-1:1]};
        rem_sh  = acc[2*XLEN-1:XLEN-1];
        rem_sub = rem_sh[XLEN-1:0] - opnd;
        div_nx  = (rem_sh >= {1'b0, opnd}) ? {rem_sub, acc[XLEN-2:0], 1'b1}
                                            : {acc[2*XLEN-2:0], 1'b0};
`ifdef MULDIV_EARLY_OUT_EN
        last = spec || (op[2] ? (cnt == 6'(XLEN)) : (mplier == '0));
        // after cnt iterations the product sits (XLEN-cnt) bits too high
        prod = acc >> (6'(XLEN) - cnt);
`else
        last = spec || (cnt == 6'(XLEN));
        prod = acc;
`endif
        prod_s = (sign_a ^ sign_b) ? -prod : prod;
        quot_s = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_s  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quot_s;
            default:                fix_res = rem_s;
        endcase
        if (spec) fix_res = acc[XLEN-1:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    if (bus.flush) state_nx = IDLE;
                     else if (last) state_nx = DONE;
            DONE:    if (bus.flush || bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            spec   <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            res_q  <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            mplier <= '0;
`endif
        end else begin
            if (accept) begin
                op     <= bus.funct3;
                sign_a <= in_sa;
                sign_b <= in_sb;
                spec   <= in_spec;
                cnt    <= '0;
                opnd   <= in_div ? in_b_abs : in_a_abs;
                // special cases park their answer in acc and skip the iterations
                acc    <= {{XLEN{1'b0}}, in_spec ? in_spec_res : (in_div ? in_a_abs : in_b_abs)};
`ifdef MULDIV_EARLY_OUT_EN
                mplier <= in_div ? '0 : in_b_abs;
`endif
            end else if (state == CALC && !bus.flush && !last) begin
                acc    <= op[2] ? div_nx : mul_nx;
                cnt    <= cnt + 6'd1;
`ifdef MULDIV_EARLY_OUT_EN
                mplier <= mplier >> 1;
`endif
            end
            if (state == CALC && state_nx == DONE) res_q <= fix_res;
            else if (state_nx != DONE)             res_q <= '0;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: results, latency, stall, flush and reset.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.XLEN(32)) bus ();
    muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // expected multiply latency from |b|
    function automatic int mul_lat(input logic [31:0] b_abs);
        int m = -1;
        for (int i = 0; i < 32; i++) if (b_abs[i]) m = i;
        return EARLY ? ((m < 0) ? 1 : m + 2) : 33;
    endfunction

    // offer one op, measure latency, hold in DONE for 'hold' cycles, then consume
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int lat = 0;
        bus.in_valid = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({tag, " in_ready after accept"}, {31'b0, bus.in_ready}, 32'd0);
        chk({tag, " result while busy"}, bus.result, 32'd0);
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, bus.result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " held result"}, bus.result, exp);
            chk({tag, " held in_ready"}, {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, " in_ready after consume"}, {31'b0, bus.in_ready}, 32'd1);
        chk({tag, " out_valid after consume"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.funct3 = '0;
        bus.op_a = '0; bus.op_b = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("MUL 7*-3",       3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, mul_lat(32'd3), 0);
        run_op("MULHU -1*-1",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, mul_lat(32'hFFFF_FFFF), 0);
        run_op("MULH -1*-1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, mul_lat(32'd1), 0);
        run_op("MULHSU -1*2",    3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, mul_lat(32'd2), 0);
        run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
        run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
        run_op("DIVU 100/7",     3'b101, 32'd100,       32'd7,         32'd14,        33, 0);
        run_op("DIVU 5/0",       3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op("REM 5/0",        3'b110, 32'd5,         32'd0,         32'd5,         1, 0);
        run_op("DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
        run_op("REMU 100/7 hold", 3'b111, 32'd100,      32'd7,         32'd2,         33, 10);

        // flush together with in_valid in IDLE: nothing accepted
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd9; bus.op_b = 32'd3;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush+valid in_ready", {31'b0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        repeat (36) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
        chk("flush+valid no out_valid", {31'b0, seen}, 32'd0);

        // flush at CALC iteration 10
        bus.in_valid = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("flush out_valid", {31'b0, bus.out_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
        chk("flush no out_valid later", {31'b0, seen}, 32'd0);

        // asynchronous reset pulse mid-CALC
        bus.in_valid = 1'b1; bus.funct3 = 3'b011; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midreset in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("midreset out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midreset result", bus.result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
        chk("midreset no out_valid later", {31'b0, seen}, 32'd0);
        run_op("MUL 3*4 after reset", 3'b000, 32'd3, 32'd4, 32'd12, mul_lat(32'd4), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide sequencer sitting beside the single-cycle ALU in the execute stage. Accepts one M-extension operation per valid/ready handshake, runs a shift-add multiplier or restoring divider for up to 32 cycles, and holds the result until the pipeline consumes it. The execute stage stalls on `in_ready`/`out_valid`. The sequencer owns its own 64-bit accumulator datapath, so the main ALU stays free.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `flush`  in  1  abort any in-flight operation (branch mispredict/trap).
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  sequencer can accept; high only in IDLE.
- `funct3`  in  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN  rs1 value (multiplicand/dividend).
- `op_b`  in  XLEN  rs2 value (multiplier/divisor).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  XLEN  rd value; 0 whenever `out_valid`=0.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `in_ready`=1. `in_valid`&&!`flush` at an edge latches `funct3`, the signs, |a| and |b| (unsigned ops take the raw values), and clears the iteration counter.
  - A special case moves directly to DONE.
  - Otherwise the block moves to CALC.
- CALC, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half of the 64-bit product; then shift right by 1.
- CALC, divide: restoring. Each cycle, shift {rem,quot} left by 1, trial-subtract the divisor, and keep the result if non-negative, setting the quotient LSB.
- CALC lasts exactly 32 iterations (counter 0..31), then the final sign fix is applied and the block enters DONE.
- Sign fix:
  - Product is negated if sign_a^sign_b (MULHSU: sign_a only).
  - Quotient is negated if sign_a^sign_b.
  - Remainder takes sign_a.
- Result select:
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Special cases (no CALC):
  - Divide by zero: quotient 0xFFFFFFFF, remainder = `op_a`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- DONE: `out_valid`=1 and `result` stable. `out_valid`&&`out_ready` at an edge returns to IDLE.
- `flush` at an edge in any state returns to IDLE; the in-flight result is discarded.
- Simultaneous `flush` and `in_valid` in IDLE: flush wins and nothing is accepted.
- Reset: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, all internal registers 0.
- Reset asserted mid-operation: immediate return to IDLE. No result is ever produced for that operation.

## Timing
- Acceptance edge = E.
- Normal operation: `out_valid` rises after edge E+33 (32 CALC iterations plus the transition into DONE).
- Special case: `out_valid` after edge E+1.
- `in_ready` drops after E and rises again after the edge where `out_ready` is seen in DONE, or after a flush edge.
- No back-to-back acceptance: at least one IDLE cycle separates operations.
- `result` and `out_valid` are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_EARLY_OUT_EN`
  - Defined: multiply leaves CALC after the iteration in which the remaining multiplier becomes 0. The product is aligned by a final shift of (32−iterations).
    - Latency = 1 + (MSB index of |b| + 1).
    - |b|==0 is treated as a special case (latency 1, product 0).
  - Undefined: multiply always takes 32 iterations. Divide is unaffected either way.

## Test plan
- MUL 7×(−3), `out_ready`=1 → `result`=0xFFFFFFEB. `out_valid` after E+33, or E+3 with `MULDIV_EARLY_OUT_EN`.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each valid after E+1. DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- Hold `out_ready`=0 for 10 cycles in DONE → `result` stable and `in_ready`=0. Raise `out_ready` → `in_ready`=1 next cycle.
- Interrupts:
  - `flush` at CALC iteration 10 → IDLE next cycle, with no `out_valid`.
  - Reset pulse mid-CALC → all outputs at reset values; a subsequent MUL 3×4 → 12.
